// File: rtl/wptr_full_if.sv
// wptr_full_if: write-side bus of the async FIFO write pointer block.
// Ports (signals): winc, wovf_clr, wq2_rptr flow into the pointer block;
//   waddr, wptr, wfull, walmost_full, wcount, woverflow flow back out.
//   slave modport is the pointer block, master modport is the write-side client.
interface wptr_full_if #(
    parameter int ADDRSIZE = 9
);
    logic                winc;
    logic                wovf_clr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wcount;
    logic                woverflow;
    modport slave (
        input  winc, wovf_clr, wq2_rptr,
        output waddr, wptr, wfull, walmost_full, wcount, woverflow
    );
    modport master (
        output winc, wovf_clr, wq2_rptr,
        input  waddr, wptr, wfull, walmost_full, wcount, woverflow
    );
endinterface

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer, full/almost-full, fill level and sticky overflow for an async FIFO.
// Ports: wclk write clock; wrst_n async active-low reset;
//   bus (slave): winc, wovf_clr, wq2_rptr (synchronized Gray read pointer) in;
//   waddr, wptr (Gray), wfull, walmost_full, wcount, woverflow out.
module wptr_full #(
    parameter int ADDRSIZE     = 9,
    parameter int AFULL_MARGIN = 4
) (
    input logic        wclk,
    input logic        wrst_n,
    wptr_full_if.slave bus
);
    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AF_LEVEL = PW'(DEPTH - AFULL_MARGIN);

    logic              wen;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wcount_q, wcount_d;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic              woverflow_q, woverflow_d;

    always_comb begin
        wen  = bus.winc & ~wfull_q;
        rbin = '0;
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it
        for (int i = 0; i <= ADDRSIZE; i++) rbin[i] = ^(bus.wq2_rptr >> i);
        wbin_d         = wbin_q + PW'(wen);
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        wcount_d       = wbin_d - rbin;
        // full when the pointers differ only in the wrap bit: in Gray that flips the top two bits
        wfull_d        = wptr_d == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
        walmost_full_d = wcount_d >= AF_LEVEL;
        woverflow_d    = (bus.winc & wfull_q) ? 1'b1 : (bus.wovf_clr ? 1'b0 : woverflow_q);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wcount_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wcount_q       <= wcount_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wcount       = wcount_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.woverflow    = woverflow_q;
endmodule
